ahb_slave_mem: RTL and testbench

AHB byte-wide memory slave: the responder for transactions initiated by the bus master on `interface_ahb_signal`. It decodes address phases, inserts a configurable number of wait states, stores write data into an internal byte array and returns read data. It also signals an ERROR response for unsupported transfers. It sits on the SLAVE side of the interface and is the design under test for the AHB bench.

---
 rtl/ahb_slave_mem.sv | 121 ++++++++++++
 tb/tb_ahb_slave_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB byte-wide memory slave with configurable wait states and a two-cycle
// ERROR response for out-of-range or unsupported transfers.
module ahb_slave_mem #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [20:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [7:0]  HWDATA,
    output logic [7:0]  HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 hready_q, hready_d;
    logic                 hresp_q, hresp_d;
    logic                 accept_c;
    logic                 okay_c;
    logic                 commit_c;

    logic [7:0] mem [DEPTH];

    assign HRDATA = rdata_q;
    assign HREADY = hready_q;
    assign HRESP  = hresp_q;

    // Next-state, address/write latch, read-data load and registered responses
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        accept_c = hready_q && HSEL && (HTRANS != 2'b00);
        okay_c   = (HTRANS == 2'b01) && ((HADDR >> ADDR_BITS) == 21'd0);
        commit_c = (state_q == ST_LAST) && write_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_LAST;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    addr_d  = HADDR[ADDR_BITS-1:0];
                    write_d = HWRITE;
                    if (!okay_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
        endcase

        // Every transition into LAST starts a fresh final data cycle.
        if ((state_d == ST_LAST) && !write_d) begin
            rdata_d = (commit_c && (addr_q == addr_d)) ? HWDATA : mem[addr_d];
        end

        hready_d = (state_d == ST_IDLE) || (state_d == ST_LAST) || (state_d == ST_ERR2);
        hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            rdata_q  <= 8'h00;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    // Reset forces IDLE asynchronously, so a pending write can never commit.
    always_ff @(posedge HCLK) begin
        if (commit_c) begin
            mem[addr_q] <= HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench: two slaves (0 and 2 wait states) driven by randomized
// and directed AHB transfers, checked against a transaction-level memory model.
module tb_ahb_slave_mem;

    localparam int unsigned AB = 8;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [20:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk;
    logic        hrst   [2];
    logic        hsel   [2];
    logic [20:0] haddr  [2];
    logic        hwrite [2];
    logic [1:0]  htrans [2];
    logic [7:0]  hwdata [2];
    logic [7:0]  hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    int          ws_of [2] = '{0, 2};
    logic [7:0]  mdl [2][256];
    bit          mval [2][256];
    logic [7:0]  exp_rd [2];
    bit          rd_known [2];
    txn_t        txq [$];
    int          errors = 0;
    int          checks = 0;

    ahb_slave_mem #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hrst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0])
    );

    ahb_slave_mem #(.ADDR_BITS(AB), .WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESET(hrst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic txn_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [20:0] a, input logic [7:0] wd);
        txn_t x;
        x.sel = s; x.trans = t; x.write = w; x.addr = a; x.wdata = wd;
        return x;
    endfunction

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        haddr[d]  = 21'd0;
        hwdata[d] = 8'h00;
    endtask

    // Plays the queued transfers on slave d with full pipelining and checks
    // every data-phase cycle against the response the model predicts.
    task automatic run(input int d);
        txn_t dp, nx;
        bit   have_dp = 0;
        bit   ok, last, r, e;
        int   idx = 0;
        int   guard = 0;
        while ((txq.size() != 0 || have_dp) && guard < 400) begin
            guard++;
            if (txq.size() != 0) begin
                hsel[d] = txq[0].sel; htrans[d] = txq[0].trans;
                hwrite[d] = txq[0].write; haddr[d] = txq[0].addr;
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
                haddr[d] = 21'($urandom);
            end
            hwdata[d] = have_dp ? dp.wdata : 8'($urandom);
            @(negedge clk);
            r = hready[d];
            e = hresp[d];
            checks += 2;
            if (have_dp) begin
                ok   = (dp.trans == 2'b01) && ((dp.addr >> AB) == 21'd0);
                last = ok ? (idx == ws_of[d]) : (idx == 1);
                if (ok && last && !dp.write) begin
                    rd_known[d] = mval[d][dp.addr[7:0]];
                    exp_rd[d]   = mdl[d][dp.addr[7:0]];
                end
                if (r !== last) begin
                    errors++;
                    $display("FAIL hready dut%0d addr=%h cyc=%0d: got %b expected %b", d, dp.addr, idx, r, last);
                end
                if (e !== !ok) begin
                    errors++;
                    $display("FAIL hresp dut%0d addr=%h cyc=%0d: got %b expected %b", d, dp.addr, idx, e, !ok);
                end
                if (last) begin
                    if (ok && dp.write) begin
                        mdl[d][dp.addr[7:0]]  = dp.wdata;
                        mval[d][dp.addr[7:0]] = 1'b1;
                    end
                    have_dp = 0;
                end
                idx++;
            end else begin
                if (r !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_hready dut%0d: got %b expected 1", d, r);
                end
                if (e !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_hresp dut%0d: got %b expected 0", d, e);
                end
            end
            if (rd_known[d]) begin
                checks++;
                if (hrdata[d] !== exp_rd[d]) begin
                    errors++;
                    $display("FAIL hrdata dut%0d: got %h expected %h", d, hrdata[d], exp_rd[d]);
                end
            end
            @(posedge clk); #1;
            if (r && txq.size() != 0) begin
                nx = txq.pop_front();
                if (nx.sel && nx.trans != 2'b00) begin
                    dp = nx; have_dp = 1; idx = 0;
                end
            end
        end
        if (guard >= 400) begin
            errors++;
            $display("FAIL timeout dut%0d: transfer sequence did not finish in 400 cycles", d);
            txq.delete();
        end
        drive_idle(d);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (hready[d] !== 1'b1) begin errors++; $display("FAIL rst_hready dut%0d: got %b expected 1", d, hready[d]); end
            if (hresp[d] !== 1'b0) begin errors++; $display("FAIL rst_hresp dut%0d: got %b expected 0", d, hresp[d]); end
            if (hrdata[d] !== 8'h00) begin errors++; $display("FAIL rst_hrdata dut%0d: got %h expected 00", d, hrdata[d]); end
            hrst[d] = 1'b0;
            exp_rd[d] = 8'h00;
            rd_known[d] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00010, 8'hA5));
        txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00010, 8'h00));
        run(0);
        checks++;
        if (hrdata[0] !== 8'hA5) begin errors++; $display("FAIL fwd_hrdata dut0: got %h expected a5", hrdata[0]); end
    endtask

    task automatic test_wait_states();
        txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00020, 8'h3C));
        txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00020, 8'h00));
        run(1);
        checks++;
        if (hrdata[1] !== 8'h3C) begin errors++; $display("FAIL ws_hrdata dut1: got %h expected 3c", hrdata[1]); end
    endtask

    task automatic test_out_of_range();
        for (int d = 0; d < 2; d++) begin
            txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00000, 8'h00));
            txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00100, 8'h77));
            txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00000, 8'h00));
            txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h10005, 8'h66));
            txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00005, 8'h00));
            run(d);
        end
    endtask

    task automatic test_unsupported();
        for (int d = 0; d < 2; d++) begin
            txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00040, 8'h12));
            txq.push_back(mk(1'b1, 2'b10, 1'b1, 21'h00040, 8'hEE));
            txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00040, 8'h00));
            txq.push_back(mk(1'b1, 2'b11, 1'b1, 21'h00040, 8'hDD));
            txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00040, 8'h00));
            run(d);
            checks++;
            if (hrdata[d] !== 8'h12) begin errors++; $display("FAIL unsup_mem dut%0d: got %h expected 12", d, hrdata[d]); end
        end
    endtask

    task automatic test_ignored();
        for (int d = 0; d < 2; d++) begin
            txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00050, 8'h44));
            txq.push_back(mk(1'b0, 2'b01, 1'b1, 21'h00050, 8'h11));
            txq.push_back(mk(1'b1, 2'b00, 1'b1, 21'h00050, 8'h22));
            txq.push_back(mk(1'b0, 2'b01, 1'b0, 21'h00050, 8'h00));
            txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00050, 8'h00));
            run(d);
        end
    endtask

    task automatic test_reset_mid();
        txq.push_back(mk(1'b1, 2'b01, 1'b1, 21'h00030, 8'h5A));
        run(1);
        hsel[1] = 1'b1; htrans[1] = 2'b01; hwrite[1] = 1'b1; haddr[1] = 21'h00030;
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 8'hC3;
        checks++;
        if (hready[1] !== 1'b0) begin errors++; $display("FAIL mid_wait dut1: got %b expected 0", hready[1]); end
        hrst[1] = 1'b1;
        #1;
        checks += 3;
        if (hready[1] !== 1'b1) begin errors++; $display("FAIL mid_rst_hready dut1: got %b expected 1", hready[1]); end
        if (hresp[1] !== 1'b0) begin errors++; $display("FAIL mid_rst_hresp dut1: got %b expected 0", hresp[1]); end
        if (hrdata[1] !== 8'h00) begin errors++; $display("FAIL mid_rst_hrdata dut1: got %h expected 00", hrdata[1]); end
        @(posedge clk); #1;
        hrst[1] = 1'b0;
        exp_rd[1] = 8'h00;
        rd_known[1] = 1'b1;
        txq.push_back(mk(1'b1, 2'b01, 1'b0, 21'h00030, 8'h00));
        run(1);
        checks++;
        if (hrdata[1] !== 8'h5A) begin errors++; $display("FAIL mid_drop dut1: got %h expected 5a", hrdata[1]); end
    endtask

    task automatic test_random();
        int k;
        logic [1:0]  t;
        logic [20:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                k = $urandom_range(0, 9);
                t = (k < 7) ? 2'b01 : (k == 7) ? 2'b00 : (k == 8) ? 2'b10 : 2'b11;
                k = $urandom_range(0, 9);
                if (k == 0)      a = 21'h00100 | 21'($urandom_range(0, 255));
                else if (k == 1) a = 21'($urandom) | 21'h100000;
                else             a = 21'($urandom_range(0, 15));
                txq.push_back(mk(1'($urandom_range(0, 9) != 0), t, 1'($urandom_range(0, 1)),
                                 a, 8'($urandom)));
            end
            run(d);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hrst[d] = 1'b1;
            rd_known[d] = 1'b0;
            exp_rd[d] = 8'h00;
            for (int a = 0; a < 256; a++) mval[d][a] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_unsupported();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
